// File: rtl/sdram_pkg.sv
// sdram_pkg: frame-phase constants, bridge states and timeout data shared by the SDRAM bridge blocks
package sdram_pkg;
   localparam logic [3:0] PH_FIRST = 4'd0;
   localparam logic [3:0] PH_START = 4'd1;
   localparam logic [3:0] PH_LAST = 4'd15;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;
   typedef enum logic [2:0] {WAIT_INIT, IDLE, ARMED, ACCESS, RESP} state_t;
endpackage

// File: rtl/sdram_phase.sv
// sdram_phase: 4-bit frame phase counter that locks to clkref the same way the SDRAM controller does
module sdram_phase
   import sdram_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clkref,
   output logic [3:0] ph,
   output logic       wrap
);
   logic adv;
   assign wrap = ph == PH_LAST && clkref;
   assign adv = wrap || (ph == PH_FIRST && !clkref) || (ph != PH_FIRST && ph != PH_LAST);
   always_ff @(posedge clk)
      if (reset) ph <= PH_FIRST;
      else if (adv) ph <= ph + 4'd1;
endmodule

// File: rtl/sdram_bridge.sv
// sdram_bridge: CPU-to-SDRAM-controller bridge issuing at most one access per 16-phase frame
module sdram_bridge
   import sdram_pkg::*;
#(
   parameter int INIT_FRAMES = 32,
   parameter int REFRESH_EVERY = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clkref,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic [25:0] sd_addr,
   output logic        sd_we,
   output logic        sd_oe,
   output logic [3:0]  sd_dqm,
   output logic [31:0] sd_din,
   input  logic [31:0] sd_dout,
   input  logic        sd_ready,
   output logic        busy,
   output logic        err
);
   localparam int FW = $clog2(INIT_FRAMES + 1);
   localparam int RW = $clog2(REFRESH_EVERY + 1);
   state_t state, next;
   logic [3:0] ph;
   logic wrap, start, rise, req, launch, ref_due, acc, rdy_q, unused_addr;
   logic [FW-1:0] fcnt;
   logic [RW-1:0] rcnt;
   logic [25:0] addr_q, l_addr;
   logic [31:0] wdata_q, l_wdata;
   logic [3:0] wstrb_q, l_wstrb;
   sdram_phase u_phase (.clk(clk), .reset(reset), .clkref(clkref), .ph(ph), .wrap(wrap));
   assign unused_addr = ^mem_addr[31:26];
   assign start = ph == PH_FIRST && !clkref;
   assign rise = sd_ready && !rdy_q;
   assign req = mem_valid && !mem_ready;
   assign ref_due = rcnt == RW'(REFRESH_EVERY);
   assign busy = state != IDLE;
   // a request seen in IDLE right at the 0->1 edge launches directly so back-to-back frames stay filled
   assign launch = start && !ref_due && (state == ARMED ? mem_valid : state == IDLE && req);
   assign l_addr = state == ARMED ? addr_q : mem_addr[25:0];
   assign l_wdata = state == ARMED ? wdata_q : mem_wdata;
   assign l_wstrb = state == ARMED ? wstrb_q : mem_wstrb;
   always_ff @(posedge clk)
      if (reset) state <= WAIT_INIT;
      else state <= next;
   always_comb begin
      next = state;
      case (state)
         WAIT_INIT: next = wrap && fcnt == FW'(INIT_FRAMES - 1) ? IDLE : WAIT_INIT;
         IDLE:      next = !req ? IDLE : launch ? ACCESS : ARMED;
         ARMED:     next = !mem_valid ? IDLE : launch ? ACCESS : ARMED;
         ACCESS:    next = wrap ? IDLE : rise ? RESP : ACCESS;
         RESP:      next = wrap ? IDLE : RESP;
         default:   next = WAIT_INIT;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         {fcnt, rcnt, acc, rdy_q, err, mem_ready} <= '0;
         {mem_rdata, addr_q, wdata_q, wstrb_q} <= '0;
         {sd_we, sd_oe, sd_addr, sd_din, sd_dqm} <= '0;
      end else begin
         rdy_q <= sd_ready;
         mem_ready <= state == ACCESS && (rise || wrap);
         if (state == IDLE && req) {addr_q, wdata_q, wstrb_q} <= {mem_addr[25:0], mem_wdata, mem_wstrb};
         if (state == ACCESS && rise) mem_rdata <= sd_dout;
         else if (state == ACCESS && wrap) begin
            mem_rdata <= TIMEOUT_DATA;
            err <= 1'b1;
         end
         if (launch) begin
            sd_we <= |l_wstrb;
            sd_oe <= ~|l_wstrb;
            sd_addr <= l_addr;
            sd_din <= l_wdata;
            sd_dqm <= |l_wstrb ? ~l_wstrb : 4'b0000;
         end else if (wrap) {sd_we, sd_oe, sd_addr, sd_din, sd_dqm} <= '0;
         // refresh count tracks consecutive access frames; any idle frame resets it
         if (launch) acc <= 1'b1;
         else if (wrap) acc <= 1'b0;
         if (wrap) rcnt <= acc ? rcnt + 1'b1 : '0;
         if (wrap && state == WAIT_INIT) fcnt <= fcnt + 1'b1;
      end
endmodule
